// File: rtl/glitch_sequencer.sv
// glitch_sequencer: walks the glitch program held in the external ROM.
// Each 12-bit instruction is fetched, decoded and executed. Execution drives
// the UART byte handshake, timed idle delays and the crowbar glitch pin.
// The block runs one pass per start request and reports busy/done.
module glitch_sequencer #(
    parameter int PROG_LEN = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [7:0]  instr_pt,
    input  logic [11:0] instr,
    output logic [7:0]  delay_num,
    input  logic [31:0] delay_len,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic        rx_valid,
    output logic        glitch_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        SEND,
        RXWAIT,
        DELAY,
        GLITCH,
        FINISH
    } state_t;

    localparam logic [1:0] OP_SEND   = 2'b00;
    localparam logic [1:0] OP_DELAY  = 2'b01;
    localparam logic [1:0] OP_GLITCH = 2'b10;

    // One past the last valid entry, widened so pc+1 cannot wrap before the compare.
    localparam logic [8:0] PROG_END = 9'(PROG_LEN);

    state_t      state;
    logic [7:0]  pc;
    logic [11:0] ir;
    logic [31:0] cnt;
    logic        adv;
    logic        at_end;

    // The ROM is addressed straight from the registered program counter.
    assign instr_pt = pc;
    assign at_end   = (({1'b0, pc} + 9'd1) == PROG_END);

    // Decide when the current instruction is complete and pc should step.
    always_comb begin
        adv = 1'b0;
        case (state)
            DECODE:        adv = ~ir[9];
            SEND:          adv = tx_valid & tx_ready & ~ir[0];
            RXWAIT:        adv = rx_valid;
            DELAY, GLITCH: adv = (cnt <= 32'd1);
            default:       adv = 1'b0;
        endcase
    end

    // Main sequencer: state, program counter and every registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= 8'd0;
            ir         <= 12'd0;
            cnt        <= 32'd0;
            delay_num  <= 8'd0;
            tx_data    <= 8'd0;
            tx_valid   <= 1'b0;
            glitch_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (abort) begin
            // Abort leaves pc and the data registers intact for inspection.
            state      <= IDLE;
            tx_valid   <= 1'b0;
            glitch_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pc    <= 8'd0;
                        busy  <= 1'b1;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    ir        <= instr;
                    delay_num <= instr[8:1];
                    state     <= DECODE;
                end
                DECODE: begin
                    // A cleared enable bit is a NOP and is handled by adv below.
                    if (ir[9]) begin
                        case (ir[11:10])
                            OP_SEND: begin
                                tx_data  <= ir[8:1];
                                tx_valid <= 1'b1;
                                state    <= SEND;
                            end
                            OP_DELAY: begin
                                cnt   <= delay_len;
                                state <= DELAY;
                            end
                            OP_GLITCH: begin
                                // Raise the pin on entry so the high time equals the cycles spent in GLITCH.
                                cnt        <= delay_len;
                                glitch_out <= 1'b1;
                                state      <= GLITCH;
                            end
                            default: begin
                                done  <= 1'b1;
                                state <= FINISH;
                            end
                        endcase
                    end
                end
                SEND: begin
                    if (tx_valid && tx_ready) begin
                        tx_valid <= 1'b0;
                        if (ir[0]) begin
                            state <= RXWAIT;
                        end
                    end
                end
                RXWAIT: begin
                    // Completion on rx_valid is handled by adv below.
                end
                DELAY: begin
                    if (cnt > 32'd1) begin
                        cnt <= cnt - 32'd1;
                    end
                end
                GLITCH: begin
                    if (cnt > 32'd1) begin
                        cnt <= cnt - 32'd1;
                    end else begin
                        glitch_out <= 1'b0;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Step to the next entry, or finish after the last one. pc is held at the last entry.
            if (adv) begin
                if (at_end) begin
                    done  <= 1'b1;
                    state <= FINISH;
                end else begin
                    pc    <= pc + 8'd1;
                    state <= FETCH;
                end
            end
        end
    end

endmodule

// File: doc/glitch_sequencer.md
Name: glitch_sequencer

Overview:
- Executes the glitch program held in the program ROM: steps the instruction pointer, decodes each 12-bit instruction, and drives the UART byte interface, delay timing and the glitch output pin.
- Sits directly downstream of the ROM, combinationally addressing it through instr_pt/delay_num.
- Runs once per start request and reports busy/done to the host control logic.

Parameters:
- PROG_LEN, 14, number of valid program entries; execution ends after entry PROG_LEN-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin program at entry 0; honoured only in IDLE
- abort  in  1  synchronous abort; returns to IDLE next edge
- instr_pt  out  8  ROM instruction address
- instr  in  12  ROM instruction, combinational from instr_pt
- delay_num  out  8  ROM delay-table index
- delay_len  in  32  ROM delay length in clk cycles, combinational from delay_num
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte when tx_valid && tx_ready
- rx_valid  in  1  one-cycle pulse, UART received a byte
- glitch_out  out  1  registered glitch pulse to crowbar driver
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on normal completion

Behaviour:
- Instruction format:
  - [11:10] opcode.
  - [9] enable; 0 = NOP, advance.
  - [8:1] arg.
  - [0] flag.
- Opcodes:
  - 00 SEND: transmit arg; if flag=1, then wait for rx_valid.
  - 01 DELAY: idle for delay_len[arg] cycles.
  - 10 GLITCH: glitch_out high for delay_len[arg] cycles.
  - 11 HALT: finish immediately.
- States: IDLE, FETCH, DECODE, SEND, RXWAIT, DELAY, GLITCH, FINISH.
- Registered pc (8b) drives instr_pt. delay_num is a register loaded from instr[8:1] in FETCH.
- IDLE:
  - start=1 -> pc<=0, FETCH.
  - start while busy is ignored.
- FETCH (1 cycle): ir<=instr, delay_num<=instr[8:1]; -> DECODE.
- DECODE (1 cycle): dispatch on ir.
  - enable=0 -> advance.
  - DELAY/GLITCH: cnt(32b)<=delay_len.
  - GLITCH: glitch_out<=1 on the same edge.
- SEND:
  - tx_data=ir[8:1]; tx_valid=1 held until the tx_valid&&tx_ready cycle.
  - On that cycle: tx_valid<=0; flag ? RXWAIT : advance.
- RXWAIT:
  - rx_valid=1 -> advance.
  - rx_valid in any other state is ignored; no latching.
- DELAY/GLITCH:
  - Each cycle: if cnt<=1 -> advance (GLITCH also drops glitch_out on that edge); else cnt<=cnt-1.
  - delay_len=N>=1 gives exactly N cycles in state; for GLITCH, exactly N cycles of glitch_out high.
  - N=0 behaves as N=1. Full 32-bit range, no wrap.
- Advance:
  - pc+1==PROG_LEN -> FINISH; else pc<=pc+1, FETCH.
  - Per-instruction overhead is 2 cycles (FETCH+DECODE).
- HALT: DECODE -> FINISH.
- FINISH: done=1 for one cycle -> IDLE; pc retained for debug.
- Reset values: state=IDLE, pc=0, instr_pt=0, delay_num=0, tx_data=0, tx_valid=0, glitch_out=0, busy=0, done=0, cnt=0.
- abort or rst in any state: next edge state=IDLE, glitch_out=0, tx_valid=0, done=0. rst has priority over abort; abort has priority over start.
- glitch_out is driven only from a flop, never combinationally.

Test Plan:
- Reset then start with ROM {SEND 0x84 flag0}, PROG_LEN=1, tx_ready tied 1 -> tx_valid high exactly 1 cycle with tx_data=0x84; done pulses; busy falls with done.
- SEND 0x0F with tx_ready low 5 cycles -> tx_valid/tx_data stable all 6 cycles; advance only after the handshake cycle.
- SEND flag=1 followed by DELAY: rx_valid pulsed before the send completes is ignored; rx_valid pulsed 10 cycles after the handshake -> FETCH of the next entry on the following cycle.
- GLITCH with delay_len=0x1F40 -> glitch_out high exactly 8000 cycles, glitch-free. GLITCH with delay_len=0 -> exactly 1 cycle high.
- Program {DELAY 1, HALT, SEND 0xAA}, delay_len=3 -> 3 DELAY cycles, done pulse, no tx_valid ever.
- abort mid-GLITCH at cycle 100 of 600000 -> glitch_out low next edge, IDLE, no done; a new start runs from pc=0. Repeat with rst mid-SEND -> all outputs at reset values next edge.
